uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmitter in `fpga_top` between several byte producers, such as the RX echo path and the LED/status reporter. It accepts one byte at a time from the granted requester and drives the transmitter's start/busy handshake. It locks the grant across multi-byte packets so their bytes are never interleaved. A watchdog releases a stalled packet lock.

---
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among
// several byte producers. A multi-byte packet keeps the grant until its last
// byte, and a watchdog drops a packet lock whose owner has gone quiet.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int LOCK_TIMEOUT = 20000,
    parameter int GID_W        = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [GID_W-1:0]     grant_id,
    output logic                 locked,
    output logic                 timeout_err
);

    localparam int               CNT_W   = ($clog2(LOCK_TIMEOUT) > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [GID_W-1:0] PTR_RST = GID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [GID_W-1:0]   ptr_q, ptr_d;
    logic [GID_W-1:0]   grantId_q, grantId_d;
    logic               locked_q, locked_d;
    logic [7:0]         txData_q, txData_d;
    logic               txStart_q, txStart_d;
    logic [NUM_REQ-1:0] reqAck_q, reqAck_d;
    logic               timeoutErr_q, timeoutErr_d;
    logic [CNT_W-1:0]   lockCnt_q, lockCnt_d;

    logic [7:0]         reqByte [NUM_REQ];
    logic               winFound;
    logic [GID_W-1:0]   winIdx;
    logic [GID_W-1:0]   candIdx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign reqByte[g] = req_data[8*g +: 8];
    end

    // Pick the winner: the lock owner alone while locked, otherwise the first
    // valid requester after the pointer (scanned far-to-near so the nearest wins).
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        candIdx  = '0;
        if (locked_q) begin
            winFound = req_valid[grantId_q];
            winIdx   = grantId_q;
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                candIdx = GID_W'((int'(ptr_q) + k) % NUM_REQ);
                if (req_valid[candIdx]) begin
                    winFound = 1'b1;
                    winIdx   = candIdx;
                end
            end
        end
    end

    // Next-state and registered-output logic for the transmit handshake and lock watchdog.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grantId_d    = grantId_q;
        locked_d     = locked_q;
        txData_d     = txData_q;
        txStart_d    = 1'b0;
        reqAck_d     = '0;
        timeoutErr_d = 1'b0;
        lockCnt_d    = locked_q ? lockCnt_q : '0;
        case (state_q)
            IDLE: begin
                if (!tx_busy && winFound) begin
                    grantId_d = winIdx;
                    ptr_d     = winIdx;
                    txData_d  = reqByte[winIdx];
                    locked_d  = !req_last[winIdx];
                    txStart_d = 1'b1;
                    reqAck_d  = NUM_REQ'(1) << winIdx;
                    lockCnt_d = '0;
                    state_d   = START;
                end else if (locked_q && !req_valid[grantId_q]) begin
                    if (lockCnt_q == CNT_MAX) begin
                        locked_d     = 1'b0;
                        timeoutErr_d = 1'b1;
                        lockCnt_d    = '0;
                    end else begin
                        lockCnt_d = lockCnt_q + CNT_W'(1);
                    end
                end
            end
            START: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; the pointer resets so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= PTR_RST;
            grantId_q    <= '0;
            locked_q     <= 1'b0;
            txData_q     <= '0;
            txStart_q    <= 1'b0;
            reqAck_q     <= '0;
            timeoutErr_q <= 1'b0;
            lockCnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grantId_q    <= grantId_d;
            locked_q     <= locked_d;
            txData_q     <= txData_d;
            txStart_q    <= txStart_d;
            reqAck_q     <= reqAck_d;
            timeoutErr_q <= timeoutErr_d;
            lockCnt_q    <= lockCnt_d;
        end
    end

    assign req_ack     = reqAck_q;
    assign tx_data     = txData_q;
    assign tx_start    = txStart_q;
    assign grant_id    = grantId_q;
    assign locked      = locked_q;
    assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios followed by randomized
// packet traffic compared against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 2;
    localparam int LOCK_TIMEOUT = 16;
    localparam int GID_W        = 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ack;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic [GID_W-1:0]     grant_id;
    logic                 locked;
    logic                 timeout_err;

    typedef struct {
        logic [7:0] data;
        int         gid;
        logic [1:0] ack;
        logic       lockedAtStart;
        int         cyc;
    } startRec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busyLen = 20;
    int          busyCnt = 0;
    logic        extBusy = 1'b0;
    logic        prevBusy = 1'b0;
    int          fallCyc = 0;
    int          strayAck = 0;
    int          ackCount = 0;
    logic        lockedSeen = 1'b0;
    startRec_t   startLog[$];
    int          toLog[$];
    logic [8:0]  feed0[$];
    logic [8:0]  feed1[$];
    logic [8:0]  model0[$];
    logic [8:0]  model1[$];
    logic [7:0]  expData[$];
    int          expReq[$];

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ack     (req_ack),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .locked      (locked),
        .timeout_err (timeout_err)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Transmitter model: busy rises the cycle after a start pulse and lasts busyLen cycles.
    always @(posedge clk) begin
        if (!rst_n) begin
            busyCnt <= 0;
        end else if (tx_start) begin
            busyCnt <= busyLen;
        end else if (busyCnt > 0) begin
            busyCnt <= busyCnt - 1;
        end
    end

    assign tx_busy = extBusy || (busyCnt != 0);

    // Hard stop in case something escapes every bounded wait.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: observed=hang expected=finish");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic driveReqs();
        logic [8:0] h;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        if (feed0.size() > 0) begin
            h = feed0[0];
            req_valid[0]    = 1'b1;
            req_data[7:0]   = h[7:0];
            req_last[0]     = h[8];
        end
        if (feed1.size() > 0) begin
            h = feed1[0];
            req_valid[1]    = 1'b1;
            req_data[15:8]  = h[7:0];
            req_last[1]     = h[8];
        end
    endtask

    task automatic applyStimulus(input int req, input logic [7:0] data, input logic last);
        if (req == 0) begin
            feed0.push_back({last, data});
        end else begin
            feed1.push_back({last, data});
        end
        driveReqs();
    endtask

    // One cycle: observe outputs at the falling edge, then let requesters react to acks.
    task automatic tick();
        startRec_t  rec;
        logic [8:0] h;
        @(negedge clk);
        cyc++;
        if (tx_start) begin
            rec.data          = tx_data;
            rec.gid           = int'(grant_id);
            rec.ack           = req_ack;
            rec.lockedAtStart = locked;
            rec.cyc           = cyc;
            startLog.push_back(rec);
        end
        if (timeout_err) toLog.push_back(cyc);
        if (locked) lockedSeen = 1'b1;
        if (req_ack != '0) ackCount++;
        if (req_ack != '0 && !tx_start) strayAck++;
        if (prevBusy && !tx_busy) fallCyc = cyc;
        prevBusy = tx_busy;
        if (req_ack[0] && feed0.size() > 0) h = feed0.pop_front();
        if (req_ack[1] && feed1.size() > 0) h = feed1.pop_front();
        driveReqs();
    endtask

    task automatic clearLogs();
        startLog.delete();
        toLog.delete();
        lockedSeen = 1'b0;
        strayAck   = 0;
        ackCount   = 0;
    endtask

    task automatic doReset();
        rst_n   = 1'b0;
        extBusy = 1'b0;
        feed0.delete();
        feed1.delete();
        driveReqs();
        tick();
        tick();
        rst_n = 1'b1;
        clearLogs();
    endtask

    task automatic waitStarts(input int n, input int budget, input string tag);
        int spent = 0;
        while (startLog.size() < n && spent < budget) begin
            tick();
            spent++;
        end
        checkOutput({tag, " start_count"}, startLog.size(), n);
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    task automatic checkStart(input int idx, input string tag, input logic [7:0] expD, input int expGid);
        if (idx < startLog.size()) begin
            checkOutput({tag, " tx_data"}, startLog[idx].data, expD);
            checkOutput({tag, " grant_id"}, startLog[idx].gid, expGid);
            checkOutput({tag, " req_ack"}, startLog[idx].ack, 32'(1) << expGid);
        end else begin
            checkOutput({tag, " missing_start"}, startLog.size(), idx + 1);
        end
    endtask

    // Transaction-level reference: round-robin over whole packets, owner keeps
    // the transmitter until its last byte, pointer starts at the last requester.
    function automatic void computeExpected();
        int         p = NUM_REQ - 1;
        int         owner = -1;
        int         pick;
        logic [8:0] h;
        expData.delete();
        expReq.delete();
        while (model0.size() + model1.size() > 0) begin
            pick = -1;
            if (owner >= 0) begin
                pick = owner;
            end else begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int i;
                    i = (p + k) % NUM_REQ;
                    if (pick < 0 && ((i == 0 && model0.size() > 0) || (i == 1 && model1.size() > 0))) pick = i;
                end
            end
            if (pick == 0) h = model0.pop_front();
            else           h = model1.pop_front();
            expData.push_back(h[7:0]);
            expReq.push_back(pick);
            p     = pick;
            owner = h[8] ? -1 : pick;
        end
    endfunction

    // Directed scenarios then randomized rounds, all in one linear sequence.
    initial begin
        int dropCyc;
        int spent;
        rst_n = 1'b0;
        driveReqs();
        doReset();

        $display("[TB] reset state");
        checkOutput("reset tx_start", tx_start, 0);
        checkOutput("reset req_ack", req_ack, 0);
        checkOutput("reset tx_data", tx_data, 0);
        checkOutput("reset grant_id", grant_id, 0);
        checkOutput("reset locked", locked, 0);
        checkOutput("reset timeout_err", timeout_err, 0);

        $display("[TB] single byte");
        busyLen = 20;
        applyStimulus(0, 8'hCC, 1'b1);
        waitStarts(1, 100, "single");
        drain(busyLen + 10);
        checkOutput("single start_once", startLog.size(), 1);
        checkStart(0, "single", 8'hCC, 0);
        checkOutput("single locked_never", lockedSeen, 0);
        checkOutput("single stray_ack", strayAck, 0);

        // Requester 0 was the last grant, so requester 1 is searched first here.
        $display("[TB] packet lock");
        clearLogs();
        applyStimulus(1, 8'hAA, 1'b0);
        applyStimulus(1, 8'hBB, 1'b0);
        applyStimulus(1, 8'hCC, 1'b1);
        applyStimulus(0, 8'h55, 1'b1);
        waitStarts(4, 4 * (busyLen + 10), "pkt");
        drain(busyLen + 10);
        checkStart(0, "pkt0", 8'hAA, 1);
        checkStart(1, "pkt1", 8'hBB, 1);
        checkStart(2, "pkt2", 8'hCC, 1);
        checkStart(3, "pkt3", 8'h55, 0);
        if (startLog.size() >= 4) begin
            checkOutput("pkt locked_after_AA", startLog[0].lockedAtStart, 1);
            checkOutput("pkt locked_after_BB", startLog[1].lockedAtStart, 1);
            checkOutput("pkt locked_after_CC", startLog[2].lockedAtStart, 0);
        end
        checkOutput("pkt locked_end", locked, 0);

        $display("[TB] round robin");
        doReset();
        busyLen = 12;
        applyStimulus(0, 8'h11, 1'b1);
        applyStimulus(0, 8'h11, 1'b1);
        applyStimulus(1, 8'h22, 1'b1);
        applyStimulus(1, 8'h22, 1'b1);
        waitStarts(4, 4 * (busyLen + 10), "rr");
        drain(busyLen + 10);
        checkStart(0, "rr0", 8'h11, 0);
        checkStart(1, "rr1", 8'h22, 1);
        checkStart(2, "rr2", 8'h11, 0);
        checkStart(3, "rr3", 8'h22, 1);
        for (int i = 1; i < startLog.size(); i++) begin
            checkOutput($sformatf("rr period%0d", i), startLog[i].cyc - startLog[i-1].cyc, busyLen + 3);
        end

        $display("[TB] watchdog");
        doReset();
        busyLen = 10;
        applyStimulus(0, 8'h01, 1'b0);
        applyStimulus(1, 8'h02, 1'b1);
        waitStarts(1, 50, "wd first");
        spent = 0;
        while (toLog.size() == 0 && spent < 200) begin
            tick();
            spent++;
        end
        checkOutput("wd fired", toLog.size(), 1);
        if (toLog.size() > 0) begin
            checkOutput("wd delay_from_busy_fall", toLog[0] - fallCyc, LOCK_TIMEOUT + 1);
            checkOutput("wd locked_cleared", locked, 0);
        end
        waitStarts(2, 50, "wd second");
        drain(busyLen + 10);
        checkStart(0, "wd0", 8'h01, 0);
        checkStart(1, "wd1", 8'h02, 1);
        if (startLog.size() >= 2 && toLog.size() > 0) begin
            checkOutput("wd locked_first", startLog[0].lockedAtStart, 1);
            checkOutput("wd grant_after_fire", startLog[1].cyc - toLog[0], 1);
        end
        checkOutput("wd pulse_once", toLog.size(), 1);

        $display("[TB] busy backpressure");
        doReset();
        extBusy = 1'b1;
        applyStimulus(0, 8'h3C, 1'b1);
        drain(15);
        checkOutput("bp no_start", startLog.size(), 0);
        checkOutput("bp no_ack", ackCount, 0);
        extBusy = 1'b0;
        dropCyc = cyc;
        waitStarts(1, 20, "bp");
        drain(busyLen + 10);
        checkStart(0, "bp", 8'h3C, 0);
        if (startLog.size() > 0) begin
            checkOutput("bp start_latency", startLog[0].cyc - dropCyc, 1);
        end

        $display("[TB] reset mid-transfer");
        doReset();
        busyLen = 20;
        applyStimulus(1, 8'hA1, 1'b0);
        applyStimulus(1, 8'hA2, 1'b0);
        applyStimulus(1, 8'hA3, 1'b1);
        waitStarts(1, 50, "rst first");
        drain(6);
        checkOutput("rst locked_before", locked, 1);
        rst_n = 1'b0;
        applyStimulus(0, 8'h5A, 1'b1);
        tick();
        checkOutput("rst tx_start", tx_start, 0);
        checkOutput("rst req_ack", req_ack, 0);
        checkOutput("rst tx_data", tx_data, 0);
        checkOutput("rst grant_id", grant_id, 0);
        checkOutput("rst locked", locked, 0);
        checkOutput("rst timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        clearLogs();
        waitStarts(3, 3 * (busyLen + 10), "rst after");
        drain(busyLen + 10);
        checkStart(0, "rst0", 8'h5A, 0);
        checkStart(1, "rst1", 8'hA2, 1);
        checkStart(2, "rst2", 8'hA3, 1);

        $display("[TB] randomized packets");
        for (int r = 0; r < 3; r++) begin
            int total;
            doReset();
            busyLen = $urandom_range(3, 15);
            model0.delete();
            model1.delete();
            for (int q = 0; q < NUM_REQ; q++) begin
                int npk;
                npk = $urandom_range(1, 3);
                for (int pk = 0; pk < npk; pk++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        logic [7:0] d;
                        logic       l;
                        d = 8'($urandom);
                        l = (b == len - 1);
                        applyStimulus(q, d, l);
                        if (q == 0) model0.push_back({l, d});
                        else        model1.push_back({l, d});
                    end
                end
            end
            computeExpected();
            total = expData.size();
            waitStarts(total, total * (busyLen + 10) + 50, $sformatf("rand%0d", r));
            drain(busyLen + 10);
            for (int i = 0; i < total; i++) begin
                checkStart(i, $sformatf("rand%0d byte%0d", r, i), expData[i], expReq[i]);
            end
            for (int i = 1; i < startLog.size(); i++) begin
                checkOutput($sformatf("rand%0d period%0d", r, i), startLog[i].cyc - startLog[i-1].cyc, busyLen + 3);
            end
            checkOutput($sformatf("rand%0d locked_end", r), locked, 0);
            checkOutput($sformatf("rand%0d stray_ack", r), strayAck, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
